// File: rtl/cellrv32_imem_responder_if.sv
// Instruction-memory bus between the i-cache block-fill engine (master)
// and the memory responder (slave). Single outstanding request.
interface cellrv32_imem_responder_if;
    logic        cached;  // request belongs to a cached block download
    logic [31:0] addr;    // access address
    logic        re;      // read request, single-cycle pulse
    logic        we;      // write request, single-cycle pulse
    logic [3:0]  ben;     // write byte enables
    logic [31:0] wdata;   // write data
    logic [31:0] rdata;   // read data, non-zero only in the ack cycle of a read
    logic        ack;     // transfer acknowledge pulse
    logic        err;     // transfer error pulse

    modport master (
        output cached, addr, re, we, ben, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  cached, addr, re, we, ben, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/cellrv32_imem_responder.sv
// Instruction-memory bus responder: decodes an aligned address window,
// serves one request at a time with programmable wait states and answers
// with a single-cycle ack or err. Consecutive cached reads skip the waits.
module cellrv32_imem_responder #(
    parameter logic [31:0] IMEM_BASE        = 32'h0000_0000,
    parameter int          IMEM_SIZE        = 16384,
    parameter bit          IMEM_AS_ROM      = 1'b0,
    parameter int          IMEM_WAIT_STATES = 2
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    cellrv32_imem_responder_if.slave        bus
);

    localparam int AW    = $clog2(IMEM_SIZE);
    localparam int WORDS = IMEM_SIZE / 4;
    localparam int IW    = (AW > 2) ? (AW - 2) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Word index inside the window; the mask keeps a 1-word window in range.
    function automatic logic [IW-1:0] word_idx(input logic [29:0] word_addr);
        return IW'(word_addr) & IW'(WORDS - 1);
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [29:0]  word_q, word_d;      // latched word address (bits [31:2])
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   ben_q, ben_d;
    logic         we_q, we_d;          // access kind: 1 = write (or error request)
    logic         cached_q, cached_d;
    logic         errp_q, errp_d;      // response will be err instead of ack

    logic         trk_valid_q;
    logic [29:0]  trk_word_q;

    logic         ack_q, err_q;
    logic [31:0]  rdata_q;

    logic [31:0]  mem [0:WORDS-1];

    logic         sel;
    logic         req;
    logic         req_err;
    logic         fast;
    logic [IW-1:0] acc_idx;

    assign sel     = (bus.addr[31:AW] == IMEM_BASE[31:AW]);
    assign req     = sel && (bus.re || bus.we);
    assign req_err = (bus.re && bus.we) || (bus.we && IMEM_AS_ROM);
    // Sequential cached read: next word after the last acked one, never
    // across the window end (that wrap goes through the normal path).
    assign fast    = bus.cached && bus.re && !bus.we && trk_valid_q &&
                     (bus.addr[31:2] == trk_word_q + 30'd1) &&
                     (word_idx(trk_word_q) != IW'(WORDS - 1));
    assign acc_idx = word_idx(word_q);

    // Next-state and request-capture logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        ben_d    = ben_q;
        we_d     = we_q;
        cached_d = cached_q;
        errp_d   = errp_q;

        unique case (state_q)
            S_IDLE: begin
                // The ack/err cycle is still "busy": requests there are dropped.
                if (req && !ack_q && !err_q) begin
                    word_d   = bus.addr[31:2];
                    wdata_d  = bus.wdata;
                    ben_d    = bus.ben;
                    we_d     = bus.we;
                    cached_d = bus.cached;
                    errp_d   = req_err;
                    cnt_d    = 4'(IMEM_WAIT_STATES);
                    if (req_err || fast || (IMEM_WAIT_STATES == 0)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and request registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
            we_q     <= 1'b0;
            cached_q <= 1'b0;
            errp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            ben_q    <= ben_d;
            we_q     <= we_d;
            cached_q <= cached_d;
            errp_q   <= errp_d;
        end
    end

    // Byte-masked memory write, performed in the response-phase cycle.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array deliberately has no reset; only control
        // state is reset, so the array maps onto plain RAM.
        if ((state_q == S_RESP) && we_q && !errp_q) begin
            for (int b = 0; b < 4; b++) begin
                if (ben_q[b]) begin
                    mem[acc_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Response pulses, read data and the sequential-read tracker.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            trk_valid_q <= 1'b0;
            trk_word_q  <= '0;
        end else begin
            ack_q   <= (state_q == S_RESP) && !errp_q;
            err_q   <= (state_q == S_RESP) && errp_q;
            rdata_q <= ((state_q == S_RESP) && !we_q && !errp_q) ? mem[acc_idx] : '0;
            if (state_q == S_RESP) begin
                if (errp_q || we_q || !cached_q) begin
                    trk_valid_q <= 1'b0;
                end else begin
                    trk_valid_q <= 1'b1;
                    trk_word_q  <= word_q;
                end
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_cellrv32_imem_responder.sv
// Self-checking bench for cellrv32_imem_responder: a RAM instance at base 0
// and a ROM instance at base 0x0001_0000 share the request signals; the
// responses are ORed (only the selected instance ever answers).
module tb_cellrv32_imem_responder;

    typedef struct {
        string       name;
        logic        cached;
        logic [31:0] addr;
        logic        re;
        logic        we;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cached, re, we;
    logic [3:0]  ben;
    logic [31:0] addr, wdata;
    logic        ack, err;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk_i = ~clk_i;

    cellrv32_imem_responder_if if_ram ();
    cellrv32_imem_responder_if if_rom ();

    assign if_ram.cached = cached;
    assign if_ram.addr   = addr;
    assign if_ram.re     = re;
    assign if_ram.we     = we;
    assign if_ram.ben    = ben;
    assign if_ram.wdata  = wdata;
    assign if_rom.cached = cached;
    assign if_rom.addr   = addr;
    assign if_rom.re     = re;
    assign if_rom.we     = we;
    assign if_rom.ben    = ben;
    assign if_rom.wdata  = wdata;

    assign ack   = if_ram.ack | if_rom.ack;
    assign err   = if_ram.err | if_rom.err;
    assign rdata = if_ram.rdata | if_rom.rdata;

    cellrv32_imem_responder #(
        .IMEM_BASE        (32'h0000_0000),
        .IMEM_SIZE        (16384),
        .IMEM_AS_ROM      (1'b0),
        .IMEM_WAIT_STATES (2)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (if_ram.slave)
    );

    cellrv32_imem_responder #(
        .IMEM_BASE        (32'h0001_0000),
        .IMEM_SIZE        (16384),
        .IMEM_AS_ROM      (1'b1),
        .IMEM_WAIT_STATES (2)
    ) dut_rom (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (if_rom.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic c, input logic [31:0] a,
                                input logic r, input logic w, input logic [3:0] b,
                                input logic [31:0] wd, input logic ea, input logic ee,
                                input logic chk, input logic [31:0] er, input int el);
        vec_t v;
        v.name = name; v.cached = c; v.addr = a; v.re = r; v.we = w; v.ben = b;
        v.wdata = wd; v.exp_ack = ea; v.exp_err = ee; v.chk_rd = chk; v.exp_rd = er;
        v.exp_lat = el;
        return v;
    endfunction

    task automatic idle_bus();
        cached = 1'b0; re = 1'b0; we = 1'b0; ben = 4'h0; addr = '0; wdata = '0;
    endtask

    // Drive one request, wait (bounded) for its response, compare it against
    // the expectation popped from the scoreboard, then check the pulse ends.
    task automatic run_req(input vec_t v, output logic [31:0] rd_out);
        vec_t        e;
        int          lat;
        logic        a, r_err, clean, both;
        logic [31:0] rd;
        exp_q.push_back(v);
        @(negedge clk_i);
        cached = v.cached; addr = v.addr; re = v.re; we = v.we; ben = v.ben; wdata = v.wdata;
        lat = 0; a = 1'b0; r_err = 1'b0; clean = 1'b1; both = 1'b0; rd = '0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                re = 1'b0; we = 1'b0;
            end
            if (ack || err) begin
                lat = k; a = ack; r_err = err; rd = rdata; both = ack && err;
            end else if (rdata != 32'h0) begin
                clean = 1'b0;
            end
        end
        e = exp_q.pop_front();
        check({e.name, " ack"}, 32'(a), 32'(e.exp_ack));
        check({e.name, " err"}, 32'(r_err), 32'(e.exp_err));
        check({e.name, " latency"}, 32'(lat), 32'(e.exp_lat));
        check({e.name, " ack_err_both"}, 32'(both), 32'h0);
        check({e.name, " rdata_before_resp"}, 32'(clean), 32'h1);
        if (e.chk_rd) begin
            check({e.name, " rdata"}, rd, e.exp_rd);
        end
        @(negedge clk_i);
        check({e.name, " pulse_end"}, {rdata[29:0], ack, err}, 32'h0);
        rd_out = rd;
    endtask

    initial begin
        logic [31:0] rd, old;
        int          n_ack, n_err, lat;
        logic        quiet;

        // Stimulus table: {inputs, expected response} on the RAM instance.
        vecs.push_back(mk("wr_10",      0, 32'h10,   0, 1, 4'hF, 32'hDEADBEEF, 1, 0, 1, 32'h0,        4));
        vecs.push_back(mk("rd_10",      0, 32'h10,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hDEADBEEF, 4));
        vecs.push_back(mk("rd_13",      0, 32'h13,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hDEADBEEF, 4));
        vecs.push_back(mk("wr_40",      0, 32'h40,   0, 1, 4'hF, 32'hA000_0040, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_44",      0, 32'h44,   0, 1, 4'hF, 32'hA000_0044, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_48",      0, 32'h48,   0, 1, 4'hF, 32'hA000_0048, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_4c",      0, 32'h4C,   0, 1, 4'hF, 32'hA000_004C, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_50",      0, 32'h50,   0, 1, 4'hF, 32'hB000_0050, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_54",      0, 32'h54,   0, 1, 4'hF, 32'hB000_0054, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("crd_40",     1, 32'h40,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hA000_0040, 4));
        vecs.push_back(mk("crd_44",     1, 32'h44,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hA000_0044, 2));
        vecs.push_back(mk("crd_48",     1, 32'h48,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hA000_0048, 2));
        vecs.push_back(mk("crd_4c",     1, 32'h4C,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hA000_004C, 2));
        vecs.push_back(mk("rd_50_nc",   0, 32'h50,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hB000_0050, 4));
        vecs.push_back(mk("crd_54",     1, 32'h54,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hB000_0054, 4));
        vecs.push_back(mk("wr_60_full", 0, 32'h60,   0, 1, 4'hF, 32'hFFFFFFFF, 1, 0, 1, 32'h0,        4));
        vecs.push_back(mk("wr_60_ben5", 0, 32'h60,   0, 1, 4'h5, 32'h11223344, 1, 0, 1, 32'h0,        4));
        vecs.push_back(mk("rd_60",      0, 32'h60,   1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hFF22FF44, 4));
        vecs.push_back(mk("rw_0_err",   0, 32'h0,    1, 1, 4'hF, 32'h12345678, 0, 1, 1, 32'h0,        2));
        vecs.push_back(mk("wr_3ff8",    0, 32'h3FF8, 0, 1, 4'hF, 32'hC000_3FF8, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_3ffc",    0, 32'h3FFC, 0, 1, 4'hF, 32'hC000_3FFC, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("wr_0",       0, 32'h0,    0, 1, 4'hF, 32'hC000_0000, 1, 0, 1, 32'h0,       4));
        vecs.push_back(mk("crd_3ff8",   1, 32'h3FF8, 1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hC000_3FF8, 4));
        vecs.push_back(mk("crd_3ffc",   1, 32'h3FFC, 1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hC000_3FFC, 2));
        vecs.push_back(mk("crd_0_wrap", 1, 32'h0,    1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hC000_0000, 4));
        vecs.push_back(mk("crd_3ff8_b", 1, 32'h3FF8, 1, 0, 4'h0, 32'h0,        1, 0, 1, 32'hC000_3FF8, 4));
        vecs.push_back(mk("crw_err",    1, 32'h3FFC, 1, 1, 4'h0, 32'h0,        0, 1, 1, 32'h0,        2));
        vecs.push_back(mk("crd_after_err", 1, 32'h3FFC, 1, 0, 4'h0, 32'h0,     1, 0, 1, 32'hC000_3FFC, 4));

        // Reset state.
        idle_bus();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset ack", 32'(ack), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset rdata", rdata, 32'h0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_reset outputs", {rdata[29:0], ack, err}, 32'h0);

        // Table-driven part.
        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i], rd);
        end

        // ROM instance: write answered with err, contents untouched.
        run_req(mk("rom_rd_before", 0, 32'h0001_0020, 1, 0, 4'h0, 32'h0, 1, 0, 0, 32'h0, 4), old);
        run_req(mk("rom_wr_err", 0, 32'h0001_0020, 0, 1, 4'hF, ~old, 0, 1, 1, 32'h0, 2), rd);
        run_req(mk("rom_rd_after", 0, 32'h0001_0020, 1, 0, 4'h0, 32'h0, 1, 0, 1, old, 4), rd);

        // Unselected requests (just past the RAM window) get no response.
        @(negedge clk_i);
        addr = 32'h0000_4000; re = 1'b1; we = 1'b0;
        @(negedge clk_i);
        re = 1'b0; we = 1'b1; wdata = 32'h0BAD_0BAD; ben = 4'hF;
        @(negedge clk_i);
        we = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (ack || err) quiet = 1'b0;
        end
        check("unselected no response", 32'(quiet), 32'h1);
        run_req(mk("rd_after_unsel", 0, 32'h10, 1, 0, 4'h0, 32'h0, 1, 0, 1, 32'hDEADBEEF, 4), rd);

        // Request while busy is dropped: exactly one ack, at latency 4.
        @(negedge clk_i);
        addr = 32'h70; we = 1'b1; wdata = 32'h5A5A5A5A; ben = 4'hF; cached = 1'b0;
        n_ack = 0; n_err = 0; lat = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                we = 1'b0; re = 1'b1; addr = 32'h10;
            end
            if (k == 2) re = 1'b0;
            if (ack) begin
                n_ack++;
                if (lat == 0) lat = k;
            end
            if (err) n_err++;
        end
        check("busy drop ack count", 32'(n_ack), 32'h1);
        check("busy drop err count", 32'(n_err), 32'h0);
        check("busy drop latency", 32'(lat), 32'h4);
        run_req(mk("rd_70", 0, 32'h70, 1, 0, 4'h0, 32'h0, 1, 0, 1, 32'h5A5A5A5A, 4), rd);

        // Request in the ack cycle is not accepted.
        @(negedge clk_i);
        addr = 32'h74; we = 1'b1; wdata = 32'h0F0F0F0F; ben = 4'hF;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk_i);
            if (k == 1) we = 1'b0;
            if (ack) begin
                lat = k;
                re = 1'b1; addr = 32'h10;
            end
        end
        check("ack_cycle first latency", 32'(lat), 32'h4);
        @(negedge clk_i);
        re = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (ack || err) quiet = 1'b0;
            @(negedge clk_i);
        end
        check("ack_cycle request dropped", 32'(quiet), 32'h1);

        // Reset during the wait phase of a write: no response, word unchanged.
        run_req(mk("wr_80", 0, 32'h80, 0, 1, 4'hF, 32'h12345678, 1, 0, 1, 32'h0, 4), rd);
        @(negedge clk_i);
        addr = 32'h80; we = 1'b1; wdata = 32'hAAAAAAAA; ben = 4'hF;
        @(negedge clk_i);
        we = 1'b0;
        rstn_i = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if (ack || err || rdata != 32'h0) quiet = 1'b0;
        end
        rstn_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (ack || err || rdata != 32'h0) quiet = 1'b0;
        end
        check("mid_reset no response", 32'(quiet), 32'h1);
        run_req(mk("rd_80_after_reset", 0, 32'h80, 1, 0, 4'h0, 32'h0, 1, 0, 1, 32'h12345678, 4), rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
